// File: rtl/display_pkg.sv
// Shared seven-segment display definitions: active-low segment constants,
// segment bit positions and digit-slot naming for the multiplexed display.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bit positions within a 7-bit active-low pattern (gfedcba).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

endpackage

// File: rtl/count_display_mux_if.sv
// Bundles the counter sample input and the display/status outputs of count_display_mux.
interface count_display_mux_if;
  logic [3:0] count_in;
  logic       count_vld;
  logic [6:0] seg;
  logic [3:0] an;
  logic [7:0] wraps;
  logic       err;

  // slave: the display block itself; master: the counter/board side driving it.
  modport slave (
    input  count_in, count_vld,
    output seg, an, wraps, err
  );

  modport master (
    output count_in, count_vld,
    input  seg, an, wraps, err
  );
endinterface

// File: rtl/hex7seg.sv
// Combinational 4-bit hex to 7-segment decoder, active-low gfedcba order.
module hex7seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/count_display_mux.sv
// Samples a 4-bit down counter, checks its sequence, counts wraps and
// time-multiplexes count / error / wrap count onto a 4-digit common-anode display.
module count_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  count_display_mux_if.slave bus
);

  logic [3:0]  r_cur;
  logic [3:0]  r_prev;
  logic        r_primed;
  logic [7:0]  r_wraps;
  logic        r_err;
  logic [15:0] r_pre;
  digit_e      r_sel;
  logic [6:0]  r_seg;
  logic [3:0]  r_an;

  logic        w_is_dec;
  logic        w_is_hold;
  logic        w_is_wrap;
  logic [3:0]  w_nib;
  logic [6:0]  w_hex_seg;
  logic [6:0]  w_seg_nxt;
  logic [3:0]  w_an_nxt;
  logic        w_pre_last;

  // Each new sample is judged against the sample before it (r_cur, which becomes prev).
  assign w_is_dec  = (bus.count_in == (r_cur - 4'd1));
  assign w_is_hold = (bus.count_in == r_cur);
  assign w_is_wrap = (r_cur == 4'h0) && (bus.count_in == 4'hF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur    <= 4'h0;
      r_prev   <= 4'h0;
      r_primed <= 1'b0;
      r_wraps  <= 8'h00;
      r_err    <= 1'b0;
    end else if (bus.count_vld) begin
      r_cur    <= bus.count_in;
      r_prev   <= r_cur;
      r_primed <= 1'b1;
      if (r_primed) begin
        if (!(w_is_dec || w_is_hold)) r_err <= 1'b1;
        if (w_is_wrap)                r_wraps <= r_wraps + 8'd1;
      end
    end
  end

  assign w_pre_last = (r_pre == 16'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= 16'd0;
      r_sel <= DIG0;
    end else if (w_pre_last) begin
      r_pre <= 16'd0;
      r_sel <= digit_e'(r_sel + 2'd1);
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end

  always_comb begin
    w_nib = r_cur;
    case (r_sel)
      DIG2:    w_nib = r_wraps[3:0];
      DIG3:    w_nib = r_wraps[7:4];
      default: w_nib = r_cur;
    endcase
  end

  hex7seg u_hex7seg (
    .i_hex (w_nib),
    .o_seg (w_hex_seg)
  );

  always_comb begin
    w_seg_nxt = w_hex_seg;
    case (r_sel)
      DIG1: w_seg_nxt = r_err ? SEG_E : SEG_BLANK;
      DIG3: w_seg_nxt = (BLANK_LEADING && (r_wraps[7:4] == 4'h0)) ? SEG_BLANK : w_hex_seg;
      default: w_seg_nxt = w_hex_seg;
    endcase
  end

  assign w_an_nxt = ~(4'b0001 << r_sel);

  // seg and an are registered together so the lit digit always matches its pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'hF;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign bus.seg   = r_seg;
  assign bus.an    = r_an;
  assign bus.wraps = r_wraps;
  assign bus.err   = r_err;

  logic w_unused;
  assign w_unused = ^{r_prev, NUM_DIGITS[0]};

endmodule

// File: doc/count_display_mux.md
# count_display_mux

Downstream consumer of the 4-bit down counter: samples the counter value, detects wrap-around (0 -> F) and illegal jumps, and time-multiplexes the result onto a 4-digit common-anode seven-segment display. It sits between the counter output and the board display pins, replacing direct LED wiring of the count.

## Interface
- REFRESH_DIV, 4: clk cycles each digit stays lit; legal range 1..65535.
- BLANK_LEADING, 1: 1 = blank digit3 when wrap count upper nibble is 0.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- count_in  in  4  down-counter value.
- count_vld  in  1  sample strobe; count_in captured on rising clk edge when 1.
- seg  out  7  segments, active-low, seg[0]=a ... seg[6]=g.
- an  out  4  digit enables, active-low, an[0]=digit0.
- wraps  out  8  wrap event count, modulo 256.
- err  out  1  sticky illegal-sequence flag.

## Operation
- Sampling: on count_vld, cur <= count_in, prev <= cur, primed <= 1 (primed cleared only by reset).
- Checks run only on samples taken while primed=1 (the first sample after reset is never checked):
  - new == prev - 1 mod 16 is legal; new == prev (hold) is legal.
  - anything else sets err=1; err is cleared by reset only.
  - prev == 0 and new == F: wrap event, wraps <= wraps + 1, rolls over 255 -> 0 without setting err.
- Digit map:
  - digit0 = hex(cur).
  - digit1 = 'E' if err, else blank.
  - digit2 = hex(wraps[3:0]).
  - digit3 = hex(wraps[7:4]); blank if BLANK_LEADING=1 and wraps[7:4]==0.
- Refresh:
  - Prescaler pre counts 0..REFRESH_DIV-1.
  - When pre == REFRESH_DIV-1, pre wraps to 0 and sel advances 0->1->2->3->0.
  - With REFRESH_DIV=1, sel advances every cycle.
- Decode patterns (active-low gfedcba): '0'=7'h40, '1'=7'h79, 'E'=7'h06, 'F'=7'h0E, blank=7'h7F. Full hex 0-F is supported.

## Timing
- Reset values (asynchronous, effective without a clock edge):
  - an=4'hF, seg=7'h7F, wraps=8'h00, err=0.
  - sel=0, pre=0, cur=0, prev=0, primed=0.
- seg and an are registered together from (sel, digit values) of the previous cycle, so they never disagree.
  - First cycle after reset release: an=4'hE and seg=decode(digit0).
- count_in sampled at edge N appears on seg at edge N+1 if digit0 is selected.
- wraps and err update at the same edge that captures the offending or wrapping sample. They appear on seg one cycle later, when the digit is selected.
- count_vld=0: no sample, no checks; refresh continues.
- Simultaneous wrap at wraps=255: rolls to 0; digit3 blanks on the next refresh if BLANK_LEADING=1.
- Reset mid-scan or mid-sequence: all state returns to reset values immediately. After release, the first sample is unchecked, so a counter restarting at any value raises no err.

## Structure
- Shared package display_pkg:
  - SEG_BLANK, SEG_E constants.
  - NUM_DIGITS = 4.
  - Segment bit-order definition.
- Sub-module hex7seg: combinational 4-bit to 7-bit active-low decoder, reused by later display blocks.
- Top-level registers: sample/check logic, wrap counter, prescaler, digit selector, output registers.

## Test plan
- Reset: drive rst=0 mid-run, no clock edge -> an=4'hF, seg=7'h7F, wraps=0, err=0 immediately.
- Down count through wrap: samples 3,2,1,0,F -> wraps=8'h01, err=0; when an=4'b1011, seg=7'h79; when an=4'b1110, seg=7'h0E.
- Refresh with REFRESH_DIV=4, count_vld held 1:
  - an = 4'b1110 for 4 cycles, then 4'b1101, 4'b1011, 4'b0111, repeating.
  - digit3 shows 7'h7F while wraps < 16.
- Illegal jump: samples 5 then 9 -> err=1 at that edge; digit1 shows 7'h06. After further legal samples 8,7, err stays 1.
- Rollover: 256 full 16-sample down cycles -> wraps returns to 8'h00, err=0; digit3 blank again.
- Reset restart: run to count 6, pulse rst low while an=4'b1011, release, then sample F,E -> err=0, wraps=0 (no false wrap or error).
